trigger_arbiter: RTL and testbench
==================================

// Module: trigger_arbiter
// PURPOSE
//   Shares the single counter step port between N_CH debounced trigger channels.
//   Sits between the input_trigger instances and the counter:
//   - queues trigger events per channel in saturating pending counters;
//   - grants channels round-robin;
//   - issues one registered step request per event, with a req/ack handshake.
// PARAMETERS
//   N_CH    8   number of trigger channels (2..8)
//   PEND_W  2   width of each per-channel pending counter (saturates at 2**PEND_W-1)
//   CH_W    3   channel index width, = $clog2(N_CH)
// PORTS
//   clk         in   1       system clock
//   rst_n       in   1       asynchronous active-low reset
//   en_i        in   1       enable new grants (tied to ena)
//   flush_i     in   1       synchronous clear of all pending counters
//   trig_i      in   N_CH    one-cycle active-high event pulses, one per channel
//   step_req_o  out  1       step request to counter; held until acked
//   step_ch_o   out  CH_W    granted channel; stable while step_req_o=1
//   step_ack_i  in   1       counter has consumed the step this cycle
//   pend_o      out  1       any pending counter non-zero
//   busy_o      out  1       FSM not in IDLE
//   drop_o      out  1       sticky drop flag (only with TRIG_DROP_FLAG_EN)
// BEHAVIOUR
//   Reset (async, rst_n=0): pending=0, rr_ptr=0, state=IDLE, step_req_o=0,
//     step_ch_o=0, pend_o=0, busy_o=0, drop_o=0.
//   Reset mid-handshake aborts the handshake: req drops at once, event is lost.
//   Pending counters:
//   - trig_i[k]=1 increments pend[k]; at max it saturates (event dropped).
//   - A grant-decrement and a trig on the same channel, same cycle: net no change.
//   - flush_i clears all counters and wins over trig_i.
//   - An in-flight request is not cancelled by flush; its ack decrements nothing
//     below 0.
//   FSM states IDLE, REQ, GAP:
//   - IDLE: if en_i and any pend!=0: pick winner = first non-zero channel scanning
//     rr_ptr, rr_ptr+1, ... wrapping mod N_CH; register step_ch_o=winner,
//     step_req_o=1; go REQ.
//   - REQ: hold req/ch. On step_ack_i=1: pend[ch]-=1, rr_ptr=(ch+1) mod N_CH,
//     step_req_o=0; go GAP. en_i=0 does not withdraw an active request.
//   - GAP: one idle cycle, so the counter sees separated pulses; go IDLE.
//   Latency:
//   - trig at cycle t -> pend updated t+1 -> step_req_o high t+2 (if idle/enabled).
//   - Max throughput: 1 step per 3 cycles when ack returns the cycle after req.
//   Ack rules: step_ack_i while step_req_o=0 is ignored. Ack is sampled on the
//     same edge as it is asserted.
//   pend_o and busy_o are combinational from registered state.
// CONFIGURATION
//   TRIG_DROP_FLAG_EN defined:
//   - drop_o exists; set when a trig arrives on a saturated channel (not flushed
//     that cycle);
//   - cleared only by flush_i or reset.
//   Undefined: no drop_o port; saturating drops are silent.
// STRUCTURE
//   Package trig_arb_pkg:
//   - state encoding (IDLE=2'd0, REQ=2'd1, GAP=2'd2);
//   - default N_CH/PEND_W and the CH_W helper.
//   Sub-module rr_pick: combinational rotating priority picker
//   (in: req vector + rr_ptr; out: valid + index).
//   Pending counters, FSM and pointer live in the top module.
// TESTING
//   1. Reset with trig_i=8'h08 held -> all outputs 0 during reset; after release
//      req at t+2, ch=3.
//   2. trig_i=8'h81 in one cycle, ack 1 cycle after each req -> grants ch0 then
//      ch7, then IDLE; pend_o=0.
//   3. Four pulses on ch2 with PEND_W=2, no ack -> pend[2]=3; drop_o=1 (with
//      macro); three acks -> three grants.
//   4. Ack withheld 10 cycles -> step_req_o and step_ch_o stable throughout;
//      en_i=0 mid-REQ -> req still held.
//   5. trig on ch5 in the same cycle as the ack for ch5 (pend=1) -> pend[5] stays
//      1; a new req follows after GAP.
//   6. flush_i with pend=8'hFF during REQ -> pend_o=0 next cycle, req held until
//      ack, no further grants.

Source files
------------

// File: rtl/trig_arb_pkg.sv
// Shared types and defaults for the trigger arbiter: FSM state encoding,
// default channel count / pending width and the channel-index width helper.
package trig_arb_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StGap  = 2'd2
   } state_e;

   localparam int unsigned NChDefault   = 8;
   localparam int unsigned PendWDefault = 2;

   function automatic int unsigned ch_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: returns the first set request bit
// found scanning from ptr_i upwards, wrapping modulo N_CH.
module rr_pick
   import trig_arb_pkg::*;
#(
   parameter int unsigned N_CH = NChDefault,
   parameter int unsigned CH_W = ch_w(N_CH)
) (
   input  logic [N_CH-1:0] req_i,
   input  logic [CH_W-1:0] ptr_i,
   output logic            valid_o,
   output logic [CH_W-1:0] idx_o
);

   logic [CH_W-1:0] cand;

   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         cand = CH_W'((32'(ptr_i) + i) % N_CH);
         if (!valid_o && req_i[cand]) begin
            valid_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/trigger_arbiter.sv
// Shares one counter step port between N_CH trigger channels: saturating per-channel
// pending counters, round-robin grant, req/ack handshake. Optional drop_o: TRIG_DROP_FLAG_EN.
module trigger_arbiter
   import trig_arb_pkg::*;
#(
   parameter int unsigned N_CH   = NChDefault,
   parameter int unsigned PEND_W = PendWDefault,
   parameter int unsigned CH_W   = ch_w(N_CH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en_i,
   input  logic            flush_i,
   input  logic [N_CH-1:0] trig_i,
   output logic            step_req_o,
   output logic [CH_W-1:0] step_ch_o,
   input  logic            step_ack_i,
   output logic            pend_o,
`ifdef TRIG_DROP_FLAG_EN
   output logic            drop_o,
`endif
   output logic            busy_o
);

   localparam logic [PEND_W-1:0] PendMax = '1;

   logic [PEND_W-1:0] pend_q [N_CH];
   logic [PEND_W-1:0] pend_d [N_CH];
   logic [N_CH-1:0]   nz;
   logic [N_CH-1:0]   dec;
   state_e            state_q, state_d;
   logic              req_q, req_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [CH_W-1:0]   rr_q, rr_d;
   logic              pick_valid;
   logic [CH_W-1:0]   pick_idx;
   logic              ack_fire;

   // Ack only counts while a request is actually outstanding.
   assign ack_fire = (state_q == StReq) && step_ack_i;

   always_comb begin
      nz  = '0;
      dec = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         nz[k]  = (pend_q[k] != '0);
         dec[k] = ack_fire && (ch_q == CH_W'(k)) && nz[k];
      end
   end

   // Trig and decrement together cancel, even on a saturated counter.
   always_comb begin
      for (int unsigned k = 0; k < N_CH; k++) begin
         pend_d[k] = pend_q[k];
         if (flush_i) begin
            pend_d[k] = '0;
         end else if (trig_i[k] && dec[k]) begin
            pend_d[k] = pend_q[k];
         end else if (trig_i[k] && (pend_q[k] != PendMax)) begin
            pend_d[k] = pend_q[k] + PEND_W'(1);
         end else if (dec[k]) begin
            pend_d[k] = pend_q[k] - PEND_W'(1);
         end
      end
   end

   rr_pick #(
      .N_CH(N_CH),
      .CH_W(CH_W)
   ) u_rr_pick (
      .req_i  (nz),
      .ptr_i  (rr_q),
      .valid_o(pick_valid),
      .idx_o  (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      ch_d    = ch_q;
      rr_d    = rr_q;
      unique case (state_q)
         StIdle: begin
            // A flush in the same cycle would orphan the grant, so hold off.
            if (en_i && !flush_i && pick_valid) begin
               ch_d    = pick_idx;
               req_d   = 1'b1;
               state_d = StReq;
            end
         end
         StReq: begin
            if (step_ack_i) begin
               req_d   = 1'b0;
               rr_d    = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);
               state_d = StGap;
            end
         end
         StGap: begin
            state_d = StIdle;
         end
         default: begin
            req_d   = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

`ifdef TRIG_DROP_FLAG_EN
   logic drop_q, drop_d;
   logic [N_CH-1:0] drop_hit;

   always_comb begin
      drop_hit = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         drop_hit[k] = trig_i[k] && !dec[k] && (pend_q[k] == PendMax);
      end
      drop_d = flush_i ? 1'b0 : (drop_q | (|drop_hit));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q <= 1'b0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_o = drop_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         req_q   <= 1'b0;
         ch_q    <= '0;
         rr_q    <= '0;
         pend_q  <= '{default: '0};
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         ch_q    <= ch_d;
         rr_q    <= rr_d;
         pend_q  <= pend_d;
      end
   end

   assign step_req_o = req_q;
   assign step_ch_o  = ch_q;
   assign pend_o     = |nz;
   assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_trigger_arbiter.sv
// Directed table-driven bench for trigger_arbiter plus hand sequences for
// saturation, long ack stall and flush during a request.
module tb_trigger_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en_i = 1'b0;
   logic       flush_i = 1'b0;
   logic       step_ack_i = 1'b0;
   logic [7:0] trig_i = '0;
   logic       step_req_o;
   logic [2:0] step_ch_o;
   logic       pend_o;
   logic       busy_o;
`ifdef TRIG_DROP_FLAG_EN
   logic       drop_o;
`endif

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   trigger_arbiter u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (en_i),
      .flush_i   (flush_i),
      .trig_i    (trig_i),
      .step_req_o(step_req_o),
      .step_ch_o (step_ch_o),
      .step_ack_i(step_ack_i),
      .pend_o    (pend_o),
`ifdef TRIG_DROP_FLAG_EN
      .drop_o    (drop_o),
`endif
      .busy_o    (busy_o)
   );

   typedef struct {
      logic       rst;
      logic [7:0] trig;
      logic       en;
      logic       ack;
      logic       flush;
      logic       e_req;
      logic [2:0] e_ch;
      logic       e_pend;
      logic       e_busy;
   } vec_t;

   vec_t tbl [26];

   function automatic vec_t mk(input logic r, input logic [7:0] t, input logic en,
                               input logic ack, input logic fl, input logic rq,
                               input logic [2:0] ch, input logic pe, input logic bu);
      vec_t v;
      v.rst = r; v.trig = t; v.en = en; v.ack = ack; v.flush = fl;
      v.e_req = rq; v.e_ch = ch; v.e_pend = pe; v.e_busy = bu;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, got, exp);
      end
   endtask

   // Apply inputs for one cycle, then settle past the edge for sampling.
   task automatic cyc(input logic [7:0] t, input logic en, input logic ack, input logic fl);
      trig_i = t; en_i = en; step_ack_i = ack; flush_i = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(output logic ok);
      ok = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (step_req_o) begin
            ok = 1'b1;
            break;
         end
         cyc(8'h00, 1'b1, 1'b0, 1'b0);
      end
   endtask

   initial begin
      logic ok;
      logic seen;

      //                rst trig  en ack fl   req ch pend busy
      tbl[0]  = mk(1, 8'h08, 1, 0, 0,  0, 0, 0, 0);
      tbl[1]  = mk(1, 8'h08, 1, 0, 0,  0, 0, 0, 0);
      tbl[2]  = mk(0, 8'h08, 1, 0, 0,  0, 0, 1, 0);
      tbl[3]  = mk(0, 8'h00, 1, 0, 0,  1, 3, 1, 1);
      tbl[4]  = mk(0, 8'h00, 1, 1, 0,  0, 3, 0, 1);
      tbl[5]  = mk(0, 8'h00, 1, 0, 0,  0, 3, 0, 0);
      tbl[6]  = mk(1, 8'h00, 1, 0, 0,  0, 0, 0, 0);
      tbl[7]  = mk(0, 8'h81, 1, 0, 0,  0, 0, 1, 0);
      tbl[8]  = mk(0, 8'h00, 1, 0, 0,  1, 0, 1, 1);
      tbl[9]  = mk(0, 8'h00, 1, 1, 0,  0, 0, 1, 1);
      tbl[10] = mk(0, 8'h00, 1, 0, 0,  0, 0, 1, 0);
      tbl[11] = mk(0, 8'h00, 1, 0, 0,  1, 7, 1, 1);
      tbl[12] = mk(0, 8'h00, 1, 1, 0,  0, 7, 0, 1);
      tbl[13] = mk(0, 8'h00, 1, 0, 0,  0, 7, 0, 0);
      tbl[14] = mk(0, 8'h20, 1, 0, 0,  0, 7, 1, 0);
      tbl[15] = mk(0, 8'h00, 1, 0, 0,  1, 5, 1, 1);
      tbl[16] = mk(0, 8'h20, 1, 1, 0,  0, 5, 1, 1);
      tbl[17] = mk(0, 8'h00, 1, 1, 0,  0, 5, 1, 0);
      tbl[18] = mk(0, 8'h00, 1, 0, 0,  1, 5, 1, 1);
      tbl[19] = mk(0, 8'h00, 1, 1, 0,  0, 5, 0, 1);
      tbl[20] = mk(0, 8'h00, 1, 0, 0,  0, 5, 0, 0);
      tbl[21] = mk(0, 8'h02, 0, 0, 0,  0, 5, 1, 0);
      tbl[22] = mk(0, 8'h00, 0, 0, 0,  0, 5, 1, 0);
      tbl[23] = mk(0, 8'h00, 1, 0, 0,  1, 1, 1, 1);
      tbl[24] = mk(0, 8'h00, 1, 1, 0,  0, 1, 0, 1);
      tbl[25] = mk(0, 8'h00, 1, 0, 0,  0, 1, 0, 0);

      for (int i = 0; i < 26; i++) begin
         rst_n = !tbl[i].rst;
         cyc(tbl[i].trig, tbl[i].en, tbl[i].ack, tbl[i].flush);
         check($sformatf("row%0d {req,ch,pend,busy}", i),
               32'({step_req_o, step_ch_o, pend_o, busy_o}),
               32'({tbl[i].e_req, tbl[i].e_ch, tbl[i].e_pend, tbl[i].e_busy}));
      end
`ifdef TRIG_DROP_FLAG_EN
      check("drop clear before saturation", 32'(drop_o), 32'd0);
`endif

      // Saturation: four pulses on ch2, counter holds three, three grants follow.
      for (int p = 0; p < 4; p++) cyc(8'h04, 1'b1, 1'b0, 1'b0);
      check("sat {req,ch}", 32'({step_req_o, step_ch_o}), 32'({1'b1, 3'd2}));
`ifdef TRIG_DROP_FLAG_EN
      check("sat drop_o", 32'(drop_o), 32'd1);
`endif
      for (int g = 0; g < 3; g++) begin
         wait_req(ok);
         check($sformatf("sat grant%0d seen", g), 32'(ok), 32'd1);
         check($sformatf("sat grant%0d ch", g), 32'(step_ch_o), 32'd2);
         cyc(8'h00, 1'b1, 1'b1, 1'b0);
      end
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         cyc(8'h00, 1'b1, 1'b0, 1'b0);
         seen |= step_req_o;
      end
      check("sat no 4th grant", 32'(seen), 32'd0);
      check("sat pend_o drained", 32'(pend_o), 32'd0);

      // Ack stall: request and channel stay put, en_i drop does not withdraw.
      cyc(8'h40, 1'b1, 1'b0, 1'b0);
      wait_req(ok);
      check("stall req seen", 32'(ok), 32'd1);
      for (int c = 0; c < 10; c++) begin
         cyc(8'h00, (c < 5), 1'b0, 1'b0);
         check($sformatf("stall c%0d {req,ch}", c), 32'({step_req_o, step_ch_o}),
               32'({1'b1, 3'd6}));
      end
      cyc(8'h00, 1'b0, 1'b1, 1'b0);
      check("stall ack {req,busy}", 32'({step_req_o, busy_o}), 32'({1'b0, 1'b1}));
      cyc(8'h00, 1'b1, 1'b0, 1'b0);
      cyc(8'h00, 1'b1, 1'b0, 1'b0);

      // Flush during REQ with every channel pending; flush also beats a trig.
      cyc(8'hFF, 1'b1, 1'b0, 1'b0);
      cyc(8'h00, 1'b1, 1'b0, 1'b0);
      check("flush grant {req,ch}", 32'({step_req_o, step_ch_o}), 32'({1'b1, 3'd7}));
`ifdef TRIG_DROP_FLAG_EN
      check("drop sticky", 32'(drop_o), 32'd1);
`endif
      cyc(8'hFF, 1'b1, 1'b0, 1'b1);
      check("flush pend_o", 32'(pend_o), 32'd0);
      check("flush req held", 32'({step_req_o, step_ch_o}), 32'({1'b1, 3'd7}));
`ifdef TRIG_DROP_FLAG_EN
      check("flush clears drop", 32'(drop_o), 32'd0);
`endif
      for (int c = 0; c < 3; c++) cyc(8'h00, 1'b1, 1'b0, 1'b0);
      check("flush req still held", 32'(step_req_o), 32'd1);
      cyc(8'h00, 1'b1, 1'b1, 1'b0);
      check("flush ack drops req", 32'(step_req_o), 32'd0);
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         cyc(8'h00, 1'b1, 1'b0, 1'b0);
         seen |= step_req_o | pend_o;
      end
      check("flush no further grants", 32'(seen), 32'd0);
      check("flush idle", 32'(busy_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
